// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a byte FIFO: pops the head byte while idle, then sends
// a start bit, DBIT data bits LSB first, and a stop period of SB_TICK oversample ticks.
module fifo_uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       empty,
   input  logic [7:0] r_data,
   output logic       rd,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   // The tick counter must reach 15 for data bits and SB_TICK-1 for the stop period.
   localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [TW-1:0] BIT_LAST  = TW'(15);
   localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DBIT - 1);

   logic [1:0]      state, state_n;
   logic [TW-1:0]   tick_cnt, tick_cnt_n;
   logic [2:0]      bit_cnt, bit_cnt_n;
   logic [DBIT-1:0] shreg, shreg_n;
   logic            tx_n, done_n;

   // Gating with reset keeps the FIFO untouched while the block is held in reset.
   assign rd      = reset && (state == IDLE) && !empty;
   assign tx_busy = (state != IDLE);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      done_n     = 1'b0;
      tx_n       = 1'b1;

      case (state)
         IDLE: begin
            // s_tick is deliberately ignored here, so the first START tick is never lost.
            if (!empty) begin
               shreg_n    = r_data[DBIT-1:0];
               tick_cnt_n = '0;
               state_n    = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (tick_cnt == BIT_LAST) begin
                  tick_cnt_n = '0;
                  bit_cnt_n  = '0;
                  state_n    = DATA;
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (tick_cnt == BIT_LAST) begin
                  tick_cnt_n = '0;
                  shreg_n    = shreg >> 1;
                  bit_cnt_n  = bit_cnt + 1'b1;
                  if (bit_cnt == DATA_LAST) begin
                     state_n = STOP;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
         end
         default: begin
            if (s_tick) begin
               if (tick_cnt == STOP_LAST) begin
                  tick_cnt_n = '0;
                  done_n     = 1'b1;
                  state_n    = IDLE;
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
         end
      endcase

      // tx is registered from the next state so the line only moves on clock edges.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_cnt_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         tx       <= tx_n;
         tx_done  <= done_n;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds an 8N1 instance and a 7-bit/2-stop instance;
// a tick-counting receiver decodes each frame and compares it with a scoreboard.
module tb_fifo_uart_tx;

   typedef struct {
      int         unit;
      logic [7:0] data;
      logic [7:0] exp_v;
   } vec_t;

   typedef struct {
      int         unit;
      logic [7:0] data;
   } push_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick;
   logic       stall;
   logic       empty0, empty1;
   logic [7:0] r_data0, r_data1;
   logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

   int         checks = 0;
   int         errors = 0;

   // Written only by the driver process.
   logic [7:0] fifo0[$];
   logic [7:0] fifo1[$];
   int         tick_div = 0;
   int         rd_cnt[2];
   int         viol = 0;
   int         push_rd = 0;
   logic       pop0, pop1;

   // Written only by the main process.
   push_t      push_buf[64];
   int         push_wr = 0;
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];

   always #5 clk = ~clk;

   fifo_uart_tx u_dut8 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .empty(empty0), .r_data(r_data0),
      .rd(rd0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
   );

   fifo_uart_tx #(.DBIT(7), .SB_TICK(32)) u_dut7 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .empty(empty1), .r_data(r_data1),
      .rd(rd1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
   );

   function automatic logic tx_of(input int u);
      return (u == 1) ? tx1 : tx0;
   endfunction

   function automatic logic busy_of(input int u);
      return (u == 1) ? busy1 : busy0;
   endfunction

   function automatic logic done_of(input int u);
      return (u == 1) ? done1 : done0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Driver: ticks every 4 clk (frozen while stall=1), FIFO pop on rd, pending pushes.
   initial begin
      empty0 = 1'b1; empty1 = 1'b1; r_data0 = 8'h00; r_data1 = 8'h00; s_tick = 1'b0;
      rd_cnt[0] = 0; rd_cnt[1] = 0;
      forever begin
         @(negedge clk);
         pop0 = rd0;
         pop1 = rd1;
         if (rd0 === 1'b1) rd_cnt[0]++;
         if (rd1 === 1'b1) rd_cnt[1]++;
         if (rd0 === 1'b1 && (empty0 || busy0 || !reset)) viol++;
         if (rd1 === 1'b1 && (empty1 || busy1 || !reset)) viol++;
         @(posedge clk);
         #1;
         if (!stall) begin
            tick_div = (tick_div == 3) ? 0 : tick_div + 1;
            s_tick   = (tick_div == 0);
         end else begin
            s_tick = 1'b0;
         end
         if (pop0 === 1'b1 && fifo0.size() > 0) void'(fifo0.pop_front());
         if (pop1 === 1'b1 && fifo1.size() > 0) void'(fifo1.pop_front());
         while (push_rd < push_wr) begin
            if (push_buf[push_rd].unit == 1) fifo1.push_back(push_buf[push_rd].data);
            else                             fifo0.push_back(push_buf[push_rd].data);
            push_rd++;
         end
         empty0  = (fifo0.size() == 0);
         empty1  = (fifo1.size() == 0);
         r_data0 = empty0 ? 8'h00 : fifo0[0];
         r_data1 = empty1 ? 8'h00 : fifo1[0];
      end
   end

   // Queue a byte for the FIFO; the expected frame (if any) goes to the scoreboard now.
   task automatic push(input int u, input logic [7:0] d, input bit framed, input logic [7:0] e);
      push_buf[push_wr].unit = u;
      push_buf[push_wr].data = d;
      push_wr++;
      if (framed) begin
         if (u == 1) exp1.push_back(e);
         else        exp0.push_back(e);
      end
   endtask

   // Returns so that a push made now lands together with an s_tick pulse,
   // making the IDLE-to-START edge coincide with a tick.
   task automatic align();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (tick_div != 3 && n < 16);
   endtask

   // Receiver: waits for the start bit, then follows the DUT tick by tick through each phase.
   task automatic rx_frame(input int u, input bit b2b, output int start_len);
      int         dbit, sb, n, need, ticks, len, bad;
      logic       val;
      logic [7:0] got, exp_v;
      bit         has;
      dbit = (u == 1) ? 7 : 8;
      sb   = (u == 1) ? 32 : 16;
      got = 8'h00; bad = 0; start_len = 0; n = 0;
      @(negedge clk);
      if (b2b) check("b2b_idle_gap", tx_of(u), 1'b0);
      while (tx_of(u) !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", n < 2000, 1'b1);
      for (int p = 0; p < dbit + 2; p++) begin
         need = (p == dbit + 1) ? sb : 16;
         val  = tx_of(u);
         if (p >= 1 && p <= dbit) got[p-1] = val;
         else if (val !== ((p == 0) ? 1'b0 : 1'b1)) bad++;
         ticks = 0;
         len   = 0;
         while (ticks < need && len < 5000) begin
            if (len > 0) @(negedge clk);
            if (tx_of(u) !== val || busy_of(u) !== 1'b1 || done_of(u) !== 1'b0) bad++;
            if (s_tick) ticks++;
            len++;
         end
         if (p == 0) start_len = len;
         else        check("phase_len", len, 4 * need);
         @(negedge clk);
      end
      check("frame_glitch", bad, 0);
      check("done_pulse", done_of(u), 1'b1);
      check("busy_after", busy_of(u), 1'b0);
      check("tx_idle_after", tx_of(u), 1'b1);
      has   = (u == 1) ? (exp1.size() > 0) : (exp0.size() > 0);
      exp_v = 8'h00;
      if (has) exp_v = (u == 1) ? exp1.pop_front() : exp0.pop_front();
      check("scoreboard_entry", has, 1'b1);
      check("frame_data", got, exp_v);
   endtask

   initial begin
      vec_t vecs[6];
      int   slen, base, n, tk, bad;

      vecs[0] = '{unit: 0, data: 8'hA5, exp_v: 8'hA5};
      vecs[1] = '{unit: 0, data: 8'h01, exp_v: 8'h01};
      vecs[2] = '{unit: 0, data: 8'h80, exp_v: 8'h80};
      vecs[3] = '{unit: 1, data: 8'h41, exp_v: 8'h41};
      vecs[4] = '{unit: 1, data: 8'hC1, exp_v: 8'h41};
      vecs[5] = '{unit: 1, data: 8'h7F, exp_v: 8'h7F};

      reset = 1'b0;
      stall = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx8", tx0, 1'b1);
      check("rst_busy8", busy0, 1'b0);
      check("rst_rd8", rd0, 1'b0);
      check("rst_done8", done0, 1'b0);
      check("rst_tx7", tx1, 1'b1);
      check("rst_busy7", busy1, 1'b0);
      @(posedge clk);
      #2 reset = 1'b1;

      // Empty FIFO held for 1000 clk.
      bad  = 0;
      base = rd_cnt[0];
      repeat (1000) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd0 !== 1'b0) bad++;
      end
      check("empty_idle", bad, 0);
      check("empty_no_rd", rd_cnt[0] - base, 0);

      // Single frames; start length 64 also proves the coinciding tick was not counted.
      for (int i = 0; i < 6; i++) begin
         base = rd_cnt[vecs[i].unit];
         align();
         push(vecs[i].unit, vecs[i].data, 1'b1, vecs[i].exp_v);
         rx_frame(vecs[i].unit, 1'b0, slen);
         check("vec_start_len", slen, 64);
         check("vec_rd_pulses", rd_cnt[vecs[i].unit] - base, 1);
      end

      // Back-to-back: three bytes at once, one idle clk between frames.
      base = rd_cnt[0];
      align();
      push(0, 8'h00, 1'b1, 8'h00);
      push(0, 8'hFF, 1'b1, 8'hFF);
      push(0, 8'h3C, 1'b1, 8'h3C);
      rx_frame(0, 1'b0, slen);
      check("b2b_start_len0", slen, 64);
      rx_frame(0, 1'b1, slen);
      check("b2b_start_len1", slen, 63);
      rx_frame(0, 1'b1, slen);
      check("b2b_start_len2", slen, 63);
      check("b2b_rd_pulses", rd_cnt[0] - base, 3);
      check("b2b_drained", empty0, 1'b1);

      // Reset in the middle of data bit 3 of 0x55; 0x3C waits behind it.
      base = rd_cnt[0];
      align();
      push(0, 8'h55, 1'b0, 8'h00);
      push(0, 8'h3C, 1'b1, 8'h3C);
      n = 0;
      @(negedge clk);
      while (tx0 !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rst_frame_started", n < 2000, 1'b1);
      tk = 0;
      n  = 0;
      while (tk < 72 && n < 2000) begin
         if (n > 0) @(negedge clk);
         if (s_tick) tk++;
         n++;
      end
      check("rst_bit3_value", tx0, 1'b0);
      @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_tx", tx0, 1'b1);
      check("rst_mid_busy", busy0, 1'b0);
      check("rst_mid_rd", rd0, 1'b0);
      check("rst_mid_done", done0, 1'b0);
      repeat (5) @(negedge clk);
      check("rst_hold_rd", rd_cnt[0] - base, 1);
      check("rst_fifo_kept", fifo0.size(), 1);
      @(posedge clk);
      #2 reset = 1'b1;
      rx_frame(0, 1'b0, slen);
      check("rst_after_rd", rd_cnt[0] - base, 2);
      check("rst_after_empty", empty0, 1'b1);

      // Tick stall of 200 clk inside START.
      align();
      push(0, 8'h96, 1'b1, 8'h96);
      fork
         rx_frame(0, 1'b0, slen);
         begin
            int k, t, bs;
            k = 0;
            @(negedge clk);
            while (tx0 !== 1'b0 && k < 2000) begin
               @(negedge clk);
               k++;
            end
            t = 0;
            while (t < 5 && k < 4000) begin
               @(negedge clk);
               if (s_tick) t++;
               k++;
            end
            @(posedge clk);
            #2 stall = 1'b1;
            bs = 0;
            repeat (200) begin
               @(negedge clk);
               if (tx0 !== 1'b0) bs++;
            end
            @(posedge clk);
            #2 stall = 1'b0;
            check("stall_tx_low", bs, 0);
         end
      join
      check("stall_start_len", slen, 264);

      check("rd_protocol", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

endmodule
